mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Single-port main-memory controller for the Phase-3 pipelined CPU.
- Serialises three requesters onto one memory port:
  - I-cache block fills (fetch-stage misses)
  - D-cache block fills (memory-stage misses)
  - D-side write-through stores
- Sequences each fill as a burst of word reads and steers the returned words, with word index and write strobes, into the requesting cache.
- Sits between fetch/memory stage caches and the shared memory model; cpu derives pipeline stalls from its busy/done outputs.

Parameters:
- ADDR_W, 16, byte-address width
- DATA_W, 16, memory word width
- BLOCK_WORDS, 8, words per cache block (16-byte block); power of two

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- icache_miss  in  1  I-cache fill request, level, held until i_fill_done
- icache_miss_addr  in  ADDR_W  faulting fetch address
- dcache_miss  in  1  D-cache fill request, level, held until d_fill_done
- dcache_miss_addr  in  ADDR_W  faulting data address
- dwrite_req  in  1  write-through store request, level, held until dwrite_ack
- dwrite_addr  in  ADDR_W  store address
- dwrite_data  in  DATA_W  store data
- mem_en  out  1  memory access enable
- mem_wr  out  1  memory write (1 = write)
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- mem_rvalid  in  1  mem_rdata valid this cycle (fixed memory latency, in order)
- fill_data  out  DATA_W  word to write into the filling cache (= mem_rdata)
- fill_word_idx  out  log2(BLOCK_WORDS)  word offset of fill_data
- i_fill_we  out  1  write fill_data into I-cache data array
- d_fill_we  out  1  write fill_data into D-cache data array
- i_fill_done  out  1  one-cycle pulse, last I word; also I-cache tag/valid write strobe
- d_fill_done  out  1  one-cycle pulse, last D word; also D-cache tag/valid write strobe
- dwrite_ack  out  1  one-cycle pulse, store issued
- busy  out  1  state != IDLE

Behaviour:
- Clock and reset:
  - Single clock, clk.
  - rst_n is asynchronous, active-low.
  - Reset forces: state IDLE, issue and return counters 0, all registered outputs 0 (mem_en, mem_wr, mem_addr, mem_wdata, busy).
- Strobe outputs:
  - fill_data, fill_word_idx, i/d_fill_we, i/d_fill_done and dwrite_ack are combinational from state, counters and mem_rvalid.
  - All of them are 0 in IDLE.
- States: IDLE, DFILL, DWRITE, IFILL.
- IDLE arbitration, evaluated each cycle, fixed priority:
  - dcache_miss -> DFILL
  - else dwrite_req -> DWRITE
  - else icache_miss -> IFILL
  - else stay in IDLE.
- Store miss: dcache_miss and dwrite_req together are served fill first, then the write.
- Fill address:
  - base = {miss_addr[ADDR_W-1:4], 4'b0}; the miss address is latched on entry to the fill state.
  - Issue k (k = 0..BLOCK_WORDS-1) drives mem_en=1, mem_wr=0, mem_addr = base + 2k.
  - Issues occur on consecutive cycles, starting the cycle after the IDLE decision.
  - After issue BLOCK_WORDS-1, mem_en=0 for the rest of the fill.
- Fill return:
  - Each mem_rvalid in DFILL/IFILL asserts the matching d_fill_we/i_fill_we.
  - fill_data = mem_rdata; fill_word_idx = return counter, which then increments.
- Fill completion:
  - The return with counter == BLOCK_WORDS-1 also pulses the matching *_fill_done.
  - State returns to IDLE next cycle; counters clear.
- DWRITE:
  - One cycle with mem_en=1, mem_wr=1, mem_addr=dwrite_addr, mem_wdata=dwrite_data, dwrite_ack=1.
  - Then IDLE.
- After any operation, at least one IDLE cycle before the next grant.
- Requester drop mid-fill (e.g. flush deasserts icache_miss): the fill completes anyway and done still pulses; no abort.
- Requester drop at grant: address latched at grant, request not rechecked.
- mem_rvalid in IDLE or DWRITE is ignored, including stale returns after reset.
- Reset mid-fill: immediate return to IDLE; no done pulse; the partially filled cache line stays invalid because its tag was never written.
- Counter widths: log2(BLOCK_WORDS)+1 bits; no wrap within a fill.

Decomposition:
- Shared package cpu_pkg holds:
  - state encoding (IDLE=2'b00, DFILL=2'b01, DWRITE=2'b10, IFILL=2'b11)
  - BLOCK_OFFSET_BITS = 4
- One natural sub-module: burst_counter, holding the issue and return counters with clear/increment/terminal-count outputs; instantiated twice.

Test Plan:
- icache_miss, addr 0x1236, memory latency 4 -> mem_addr 0x1230..0x123E on 8 consecutive cycles; 8 i_fill_we with idx 0..7; i_fill_done on the 8th; busy low one cycle later.
- dcache_miss and icache_miss asserted in the same cycle -> DFILL served first (d_fill_done), one IDLE cycle, then IFILL; no i_fill_we during DFILL.
- dwrite_req addr 0x4002, data 0xBEEF, from IDLE -> next cycle mem_en=1, mem_wr=1, mem_addr 0x4002, mem_wdata 0xBEEF, dwrite_ack=1; busy for exactly 1 cycle.
- Store miss (dcache_miss and dwrite_req together) -> full D fill completes, then DWRITE, ack after d_fill_done.
- icache_miss dropped after 3 returns -> remaining 5 words still written; i_fill_done pulses.
- rst_n low after 4 returns of a D fill -> outputs 0 immediately; later mem_rvalid pulses produce no d_fill_we; a new request after release starts at word 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: arbiter state encoding and cache block geometry.
package cpu_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      DFILL  = 2'b01,
      DWRITE = 2'b10,
      IFILL  = 2'b11
   } state_t;

   // 16-byte cache blocks: low address bits below this are the in-block offset.
   localparam int BLOCK_OFFSET_BITS = 4;

endpackage

// File: rtl/burst_counter.sv
// Burst word counter: synchronous clear beats increment; tc flags the last word.
module burst_counter #(
   parameter int W    = 4,
   parameter int LAST = 7
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count,
   output logic         tc
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   count <= '0;
      else if (clr) count <= '0;
      else if (inc) count <= count + W'(1);
   end

   assign tc = (count == W'(LAST));

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: D-fill > D-store > I-fill, burst fills steered to the
// requesting cache. Issue/return counters run independently so any fixed latency works.
module mem_arbiter
   import cpu_pkg::*;
#(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 16,
   parameter int BLOCK_WORDS = 8
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           icache_miss,
   input  logic [ADDR_W-1:0]              icache_miss_addr,
   input  logic                           dcache_miss,
   input  logic [ADDR_W-1:0]              dcache_miss_addr,
   input  logic                           dwrite_req,
   input  logic [ADDR_W-1:0]              dwrite_addr,
   input  logic [DATA_W-1:0]              dwrite_data,
   output logic                           mem_en,
   output logic                           mem_wr,
   output logic [ADDR_W-1:0]              mem_addr,
   output logic [DATA_W-1:0]              mem_wdata,
   input  logic [DATA_W-1:0]              mem_rdata,
   input  logic                           mem_rvalid,
   output logic [DATA_W-1:0]              fill_data,
   output logic [$clog2(BLOCK_WORDS)-1:0] fill_word_idx,
   output logic                           i_fill_we,
   output logic                           d_fill_we,
   output logic                           i_fill_done,
   output logic                           d_fill_done,
   output logic                           dwrite_ack,
   output logic                           busy
);

   localparam int IDX_W = $clog2(BLOCK_WORDS);
   localparam int CNT_W = IDX_W + 1;
   localparam logic [ADDR_W-1:0] OFS_MASK = ADDR_W'((1 << BLOCK_OFFSET_BITS) - 1);

   state_t            state;
   logic [ADDR_W-1:0] base_q;
   logic [CNT_W-1:0]  issue_cnt, ret_cnt;
   logic              issue_tc, ret_tc;
   logic              fill_st, ret_fire, fill_last, cnt_clr;

   assign fill_st   = (state == DFILL) || (state == IFILL);
   assign ret_fire  = fill_st && mem_rvalid;
   assign fill_last = ret_fire && ret_tc;
   assign cnt_clr   = !fill_st || fill_last;

   // issue_cnt is the index of the read currently on the port
   burst_counter #(.W(CNT_W), .LAST(BLOCK_WORDS-1)) u_issue_cnt (
      .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .inc(fill_st && !issue_tc),
      .count(issue_cnt), .tc(issue_tc)
   );

   burst_counter #(.W(CNT_W), .LAST(BLOCK_WORDS-1)) u_ret_cnt (
      .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .inc(ret_fire),
      .count(ret_cnt), .tc(ret_tc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         base_q    <= '0;
         mem_en    <= 1'b0;
         mem_wr    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (dcache_miss) begin
                  state    <= DFILL;
                  base_q   <= dcache_miss_addr & ~OFS_MASK;
                  mem_addr <= dcache_miss_addr & ~OFS_MASK;
                  mem_en   <= 1'b1;
                  mem_wr   <= 1'b0;
                  busy     <= 1'b1;
               end else if (dwrite_req) begin
                  state     <= DWRITE;
                  mem_addr  <= dwrite_addr;
                  mem_wdata <= dwrite_data;
                  mem_en    <= 1'b1;
                  mem_wr    <= 1'b1;
                  busy      <= 1'b1;
               end else if (icache_miss) begin
                  state    <= IFILL;
                  base_q   <= icache_miss_addr & ~OFS_MASK;
                  mem_addr <= icache_miss_addr & ~OFS_MASK;
                  mem_en   <= 1'b1;
                  mem_wr   <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            DWRITE: begin
               state  <= IDLE;
               mem_en <= 1'b0;
               mem_wr <= 1'b0;
               busy   <= 1'b0;
            end
            default: begin
               // fill completes even if the requester dropped its miss
               if (fill_last) begin
                  state  <= IDLE;
                  mem_en <= 1'b0;
                  busy   <= 1'b0;
               end else begin
                  mem_en <= !issue_tc;
                  if (!issue_tc)
                     mem_addr <= base_q + ADDR_W'({issue_cnt + CNT_W'(1), 1'b0});
               end
            end
         endcase
      end
   end

   assign fill_data     = ret_fire ? mem_rdata : '0;
   assign fill_word_idx = ret_fire ? IDX_W'(ret_cnt) : '0;
   assign i_fill_we     = ret_fire && (state == IFILL);
   assign d_fill_we     = ret_fire && (state == DFILL);
   assign i_fill_done   = fill_last && (state == IFILL);
   assign d_fill_done   = fill_last && (state == DFILL);
   assign dwrite_ack    = (state == DWRITE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter against a fixed-latency (4) memory model.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        icache_miss, dcache_miss, dwrite_req;
   logic [15:0] icache_miss_addr, dcache_miss_addr, dwrite_addr, dwrite_data;
   logic        mem_en, mem_wr;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_rvalid;
   logic [15:0] fill_data;
   logic [2:0]  fill_word_idx;
   logic        i_fill_we, d_fill_we, i_fill_done, d_fill_done, dwrite_ack, busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(16), .DATA_W(16), .BLOCK_WORDS(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .icache_miss(icache_miss), .icache_miss_addr(icache_miss_addr),
      .dcache_miss(dcache_miss), .dcache_miss_addr(dcache_miss_addr),
      .dwrite_req(dwrite_req), .dwrite_addr(dwrite_addr), .dwrite_data(dwrite_data),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
      .fill_data(fill_data), .fill_word_idx(fill_word_idx),
      .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
      .i_fill_done(i_fill_done), .d_fill_done(d_fill_done),
      .dwrite_ack(dwrite_ack), .busy(busy)
   );

   // memory: read data = address ^ 5A5A, returned 4 cycles after issue
   logic [3:0]  rv_pipe = '0;
   logic [15:0] ad_pipe [4];
   always @(posedge clk) begin
      rv_pipe    <= {rv_pipe[2:0], mem_en && !mem_wr};
      ad_pipe[0] <= mem_addr;
      ad_pipe[1] <= ad_pipe[0];
      ad_pipe[2] <= ad_pipe[1];
      ad_pipe[3] <= ad_pipe[2];
   end
   assign mem_rvalid = rv_pipe[3];
   assign mem_rdata  = rv_pipe[3] ? (ad_pipe[3] ^ 16'h5A5A) : 16'hDEAD;

   int          n_iss, n_ret, n_ack, n_wrong, done_cyc;
   bit          tmo;
   logic [15:0] iss_addr [8];
   int          iss_cyc  [8];
   int          ret_idx  [8];
   logic [15:0] ret_data [8];

   // Records one fill as seen at negedges; cycle 0 is the first cycle after grant.
   task automatic watch_fill(input bit side_d, input int drop_after, input int stop_after);
      n_iss = 0; n_ret = 0; n_ack = 0; n_wrong = 0; done_cyc = -1; tmo = 1'b1;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (mem_en && !mem_wr) begin
            if (n_iss < 8) begin iss_addr[n_iss] = mem_addr; iss_cyc[n_iss] = c; end
            n_iss++;
         end
         if (dwrite_ack) n_ack++;
         if (side_d ? i_fill_we : d_fill_we) n_wrong++;
         if (side_d ? d_fill_we : i_fill_we) begin
            if (n_ret < 8) begin ret_idx[n_ret] = int'(fill_word_idx); ret_data[n_ret] = fill_data; end
            n_ret++;
         end
         if (side_d ? d_fill_done : i_fill_done) begin
            done_cyc = c; tmo = 1'b0;
            if (side_d) dcache_miss = 1'b0; else icache_miss = 1'b0;
            break;
         end
         if (n_ret == drop_after) begin
            if (side_d) dcache_miss = 1'b0; else icache_miss = 1'b0;
         end
         if (n_ret == stop_after) begin tmo = 1'b0; break; end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; icache_miss = 0; dcache_miss = 0; dwrite_req = 0;
      icache_miss_addr = 0; dcache_miss_addr = 0; dwrite_addr = 0; dwrite_data = 0;
      repeat (3) @(negedge clk);
      checks++;
      if ({mem_en, mem_wr, mem_addr, mem_wdata, busy} !== 35'd0)
         begin errors++; $display("FAIL reset_regs got en=%b wr=%b addr=%h wd=%h busy=%b want all 0", mem_en, mem_wr, mem_addr, mem_wdata, busy); end
      checks++;
      if ({i_fill_we, d_fill_we, i_fill_done, d_fill_done, dwrite_ack, fill_word_idx, fill_data} !== 24'd0)
         begin errors++; $display("FAIL reset_strobes got nonzero strobe want 0"); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_ifill();
      icache_miss = 1'b1; icache_miss_addr = 16'h1236;
      watch_fill(1'b0, -1, -1);
      checks++;
      if (tmo || n_iss !== 8 || n_ret !== 8 || done_cyc !== 11)
         begin errors++; $display("FAIL ifill_shape got tmo=%0d iss=%0d ret=%0d done=%0d want 0 8 8 11", tmo, n_iss, n_ret, done_cyc); end
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (iss_addr[k] !== 16'h1230 + 16'(2*k) || iss_cyc[k] !== k)
            begin errors++; $display("FAIL ifill_issue%0d got %h@%0d want %h@%0d", k, iss_addr[k], iss_cyc[k], 16'h1230 + 16'(2*k), k); end
         checks++;
         if (ret_idx[k] !== k || ret_data[k] !== ((16'h1230 + 16'(2*k)) ^ 16'h5A5A))
            begin errors++; $display("FAIL ifill_ret%0d got idx=%0d data=%h want idx=%0d", k, ret_idx[k], ret_data[k], k); end
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL ifill_busy_after got %b want 0", busy); end
   endtask

   task automatic test_priority();
      dcache_miss = 1'b1; dcache_miss_addr = 16'h2222;
      icache_miss = 1'b1; icache_miss_addr = 16'h4444;
      watch_fill(1'b1, -1, -1);
      checks++;
      if (tmo || n_ret !== 8 || n_wrong !== 0 || iss_addr[0] !== 16'h2220 || done_cyc !== 11)
         begin errors++; $display("FAIL prio_dfill got tmo=%0d ret=%0d wrong=%0d a0=%h done=%0d want 0 8 0 2220 11", tmo, n_ret, n_wrong, iss_addr[0], done_cyc); end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || mem_en !== 1'b0)
         begin errors++; $display("FAIL prio_idle_gap got busy=%b en=%b want 0 0", busy, mem_en); end
      watch_fill(1'b0, -1, -1);
      checks++;
      if (tmo || n_ret !== 8 || n_wrong !== 0 || iss_addr[0] !== 16'h4440 || iss_cyc[0] !== 0)
         begin errors++; $display("FAIL prio_ifill got tmo=%0d ret=%0d wrong=%0d a0=%h c0=%0d want 0 8 0 4440 0", tmo, n_ret, n_wrong, iss_addr[0], iss_cyc[0]); end
      @(negedge clk);
   endtask

   task automatic test_dwrite();
      dwrite_req = 1'b1; dwrite_addr = 16'h4002; dwrite_data = 16'hBEEF;
      @(negedge clk);
      checks++;
      if ({mem_en, mem_wr, dwrite_ack, busy} !== 4'b1111 || mem_addr !== 16'h4002 || mem_wdata !== 16'hBEEF)
         begin errors++; $display("FAIL dwrite_issue got en=%b wr=%b ack=%b busy=%b addr=%h wd=%h want 1 1 1 1 4002 beef", mem_en, mem_wr, dwrite_ack, busy, mem_addr, mem_wdata); end
      dwrite_req = 1'b0;
      @(negedge clk);
      checks++;
      if ({mem_en, dwrite_ack, busy} !== 3'b000)
         begin errors++; $display("FAIL dwrite_after got en=%b ack=%b busy=%b want 0 0 0", mem_en, dwrite_ack, busy); end
   endtask

   task automatic test_store_miss();
      dcache_miss = 1'b1; dcache_miss_addr = 16'h2468;
      dwrite_req = 1'b1; dwrite_addr = 16'h2460; dwrite_data = 16'h1234;
      watch_fill(1'b1, -1, -1);
      checks++;
      if (tmo || n_ret !== 8 || n_ack !== 0 || iss_addr[7] !== 16'h246E)
         begin errors++; $display("FAIL smiss_fill got tmo=%0d ret=%0d ack=%0d a7=%h want 0 8 0 246e", tmo, n_ret, n_ack, iss_addr[7]); end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || dwrite_ack !== 1'b0)
         begin errors++; $display("FAIL smiss_gap got busy=%b ack=%b want 0 0", busy, dwrite_ack); end
      @(negedge clk);
      checks++;
      if (dwrite_ack !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 16'h2460 || mem_wdata !== 16'h1234)
         begin errors++; $display("FAIL smiss_write got ack=%b wr=%b addr=%h wd=%h want 1 1 2460 1234", dwrite_ack, mem_wr, mem_addr, mem_wdata); end
      dwrite_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_drop_midfill();
      icache_miss = 1'b1; icache_miss_addr = 16'h0ABC;
      watch_fill(1'b0, 3, -1);
      checks++;
      if (tmo || n_ret !== 8 || done_cyc !== 11 || ret_idx[7] !== 7 || ret_data[7] !== (16'h0ABE ^ 16'h5A5A))
         begin errors++; $display("FAIL drop_fill got tmo=%0d ret=%0d done=%0d idx7=%0d d7=%h want 0 8 11 7 %h", tmo, n_ret, done_cyc, ret_idx[7], ret_data[7], 16'h0ABE ^ 16'h5A5A); end
      @(negedge clk);
   endtask

   task automatic test_reset_midfill();
      int stale_rv, stale_we;
      dcache_miss = 1'b1; dcache_miss_addr = 16'h3004;
      watch_fill(1'b1, -1, 4);
      checks++;
      if (tmo || n_ret !== 4) begin errors++; $display("FAIL rst_pre got tmo=%0d ret=%0d want 0 4", tmo, n_ret); end
      rst_n = 1'b0; dcache_miss = 1'b0;
      #1;
      checks++;
      if ({mem_en, busy, d_fill_we, d_fill_done} !== 4'b0000)
         begin errors++; $display("FAIL rst_async got en=%b busy=%b we=%b done=%b want 0 0 0 0", mem_en, busy, d_fill_we, d_fill_done); end
      stale_rv = 0; stale_we = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (c == 0) rst_n = 1'b1;
         if (mem_rvalid) stale_rv++;
         if (d_fill_we || i_fill_we || d_fill_done) stale_we++;
      end
      checks++;
      if (stale_rv !== 3 || stale_we !== 0)
         begin errors++; $display("FAIL rst_stale got rvalid=%0d we=%0d want 3 0", stale_rv, stale_we); end
      dcache_miss = 1'b1; dcache_miss_addr = 16'h3010;
      watch_fill(1'b1, -1, -1);
      checks++;
      if (tmo || n_ret !== 8 || iss_addr[0] !== 16'h3010 || ret_idx[0] !== 0 || done_cyc !== 11)
         begin errors++; $display("FAIL rst_refill got tmo=%0d ret=%0d a0=%h idx0=%0d done=%0d want 0 8 3010 0 11", tmo, n_ret, iss_addr[0], ret_idx[0], done_cyc); end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_ifill();
      test_priority();
      test_dwrite();
      test_store_miss();
      test_drop_midfill();
      test_reset_midfill();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
